bus_master: RTL and testbench
=============================

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter: TIMEOUT, default 255, cycles allowed waiting for hlda or _ready before abort (range 2..255).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  start pulse; sampled only in IDLE.
REQ-005 req_wr, req_mio  input  1 each  1=write/0=read; 1=memory/0=I/O.
REQ-006 req_addr  input  24  byte address; req_word input 1 (1=16-bit, 0=8-bit); req_wdata input 16.
REQ-007 busy, done, err  output  1 each  busy=not IDLE; done=1-cycle completion pulse; err=valid with done, 1 on abort.
REQ-008 rdata  output  16  read result, valid from done until next accepted req.
REQ-009 hold  output  1, hlda  input  1  bus request/grant.
REQ-010 bus_oe  output  1  enables driving a, _bhe, _ble, _ads, wr, mio, dc.
REQ-011 a  output  23 ([23:1]); _bhe, _ble, _ads  output  1 each  active-low; wr, mio, dc  output  1 each.
REQ-012 d_out  output  16; d_oe  output  1; d_in  input  16; _ready  input  1 active-low.

Function
REQ-013 States: IDLE, HREQ, TS, TC, REL; one state per cycle except HREQ/TC which wait.
REQ-014 IDLE: req=1 latches all req_* inputs, clears err/counter, goes to HREQ; hold=1 from next cycle.
REQ-015 HREQ: hlda=1 -> TS; counter reaching TIMEOUT -> REL with err=1.
REQ-016 TS (exactly 1 cycle): bus_oe=1, _ads=0, a/_bhe/_ble/wr/mio valid, dc=1; -> TC.
REQ-017 TC: _ads=1, other controls held; d_oe=wr for whole TC; _ready sampled each cycle.
REQ-018 TC with _ready=0: latch read lanes per REQ-021; if a second part is pending -> TS for it, else REL.
REQ-019 TC timeout (counter=TIMEOUT, counter reset per part) or hlda=0 in TS/TC -> REL with err=1.
REQ-020 Lanes: even word -> _bhe=0,_ble=0, d_out=wdata; byte at even -> _ble=0 only, d_out[7:0]=wdata[7:0]; byte at odd -> _bhe=0 only, d_out[15:8]=wdata[7:0].
REQ-021 Odd-address word: split into part 1 = odd byte at addr (high lane, wdata[7:0]/rdata[7:0] from d_in[15:8]), part 2 = even byte at addr+1 (low lane, wdata[15:8]/rdata[15:8] from d_in[7:0]); addr+1 wraps 24'hFFFFFF -> 0.
REQ-022 Byte reads: rdata[15:8]=0; rdata lanes written only on _ready=0 in TC of a read.
REQ-023 REL (1 cycle): hold=0, bus_oe=0, d_oe=0, _ads=1, done=1; -> IDLE.
REQ-024 req while busy ignored (no queueing); req in REL cycle ignored.
REQ-025 _ads never low two consecutive cycles; _ads low only when bus_oe=1 and hlda=1.
REQ-026 Outputs registered; no combinational path from any input to any output.

Reset
REQ-027 reset=1 forces immediately: state IDLE, hold=0, bus_oe=0, d_oe=0, _ads=1, _bhe=1, _ble=1, wr=0, mio=0, dc=0, a=0, d_out=0, rdata=0, busy=0, done=0, err=0, counter=0.
REQ-028 Reset during any state aborts without done pulse; first req after release accepted normally.

Verification
REQ-029 Word read mio=1 addr 0x012344, hlda after 3 cycles, _ready after 2 TC cycles, d_in=0xBEEF -> a=0x0091A2, _bhe=_ble=0, one _ads pulse, rdata=0xBEEF, done=1 err=0.
REQ-030 Word write addr 0x000101 wdata 0xA55A -> part 1 a=0x80 _bhe=0 d_out[15:8]=0x5A; part 2 a=0x81 _ble=0 d_out[7:0]=0xA5; two _ads pulses, one done.
REQ-031 Byte read I/O addr 0x000061, d_in=0x7F00 -> mio=0, _bhe=0 _ble=1, rdata=0x007F.
REQ-032 hlda never asserted, TIMEOUT=255 -> done=1 err=1 after 255 HREQ cycles, no _ads pulse, hold released.
REQ-033 _ready held high in TC -> err=1 after TIMEOUT cycles; hlda dropped in TC -> err=1 next cycle.
REQ-034 reset asserted in TC of a write -> d_oe=0, hold=0, _ads=1 same cycle; no done; subsequent byte write completes err=0.

Source files
------------

// File: rtl/bus_master.sv
// Bus master that turns a one-cycle req into a hold/hlda-arbitrated bus cycle,
// splitting odd-address word accesses into two single-byte parts.
module bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_mio,
  input  logic [23:0] req_addr,
  input  logic        req_word,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        hold,
  input  logic        hlda,
  output logic        bus_oe,
  output logic [23:1] a,
  output logic        _bhe,
  output logic        _ble,
  output logic        _ads,
  output logic        wr,
  output logic        mio,
  output logic        dc,
  output logic [15:0] d_out,
  output logic        d_oe,
  input  logic [15:0] d_in,
  input  logic        _ready,
  output logic [2:0]  state_dbg
);

  // Handshake: req is a one-cycle start strobe taken only while busy=0 (IDLE);
  // completion is a one-cycle done with err and rdata valid alongside it.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HREQ = 3'd1,
    TS   = 3'd2,
    TC   = 3'd3,
    REL  = 3'd4
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [23:0] lat_addr;
  logic        lat_wr;
  logic        lat_mio;
  logic        lat_word;
  logic [15:0] lat_wdata;
  logic        part;
  logic [7:0]  cnt;

  logic        full_word;
  logic        second_pending;
  logic        nxt_part;
  logic [23:0] part_addr;
  logic [7:0]  wbyte;
  logic        lane_bhe_n;
  logic        lane_ble_n;
  logic [15:0] lane_dout;
  logic        go_ts;
  logic        go_tc;
  logic        go_rel;
  logic        rel_err;
  logic        cnt_inc;
  logic        capture;

  assign state_dbg = state;

  // Bus setup for the part about to start: the second part only ever starts from TC.
  always_comb begin
    full_word      = lat_word && !lat_addr[0];
    second_pending = lat_word && lat_addr[0] && !part;
    nxt_part       = (state == TC);
    part_addr      = nxt_part ? (lat_addr + 24'd1) : lat_addr;
    wbyte          = nxt_part ? lat_wdata[15:8] : lat_wdata[7:0];
    lane_bhe_n     = 1'b1;
    lane_ble_n     = 1'b1;
    lane_dout      = 16'h0000;
    if (full_word) begin
      lane_bhe_n = 1'b0;
      lane_ble_n = 1'b0;
      lane_dout  = lat_wdata;
    end else if (part_addr[0]) begin
      lane_bhe_n = 1'b0;
      lane_dout  = {wbyte, 8'h00};
    end else begin
      lane_ble_n = 1'b0;
      lane_dout  = {8'h00, wbyte};
    end
  end

  always_comb begin
    go_ts   = 1'b0;
    go_tc   = 1'b0;
    go_rel  = 1'b0;
    rel_err = 1'b0;
    cnt_inc = 1'b0;
    capture = 1'b0;
    case (state)
      HREQ: begin
        if (hlda) begin
          go_ts = 1'b1;
        end else if (cnt == LIMIT) begin
          go_rel  = 1'b1;
          rel_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TS: begin
        if (!hlda) begin
          go_rel  = 1'b1;
          rel_err = 1'b1;
        end else begin
          go_tc = 1'b1;
        end
      end
      TC: begin
        if (!hlda) begin
          go_rel  = 1'b1;
          rel_err = 1'b1;
        end else if (!_ready) begin
          capture = !lat_wr;
          if (second_pending) go_ts = 1'b1;
          else go_rel = 1'b1;
        end else if (cnt == LIMIT) begin
          go_rel  = 1'b1;
          rel_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= 24'h0;
      lat_wr    <= 1'b0;
      lat_mio   <= 1'b0;
      lat_word  <= 1'b0;
      lat_wdata <= 16'h0;
      part      <= 1'b0;
      cnt       <= 8'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 16'h0;
      hold      <= 1'b0;
      bus_oe    <= 1'b0;
      a         <= 23'h0;
      _bhe      <= 1'b1;
      _ble      <= 1'b1;
      _ads      <= 1'b1;
      wr        <= 1'b0;
      mio       <= 1'b0;
      dc        <= 1'b0;
      d_out     <= 16'h0;
      d_oe      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= req_addr;
            lat_wr    <= req_wr;
            lat_mio   <= req_mio;
            lat_word  <= req_word;
            lat_wdata <= req_wdata;
            part      <= 1'b0;
            cnt       <= 8'h0;
            err       <= 1'b0;
            hold      <= 1'b1;
            busy      <= 1'b1;
            state     <= HREQ;
          end
        end
        REL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase

      if (cnt_inc) cnt <= cnt + 8'd1;

      // Odd-word part 1 lands on the high lane, part 2 on the low lane.
      if (capture) begin
        if (full_word) rdata <= d_in;
        else if (part) rdata[15:8] <= d_in[7:0];
        else if (lat_word) rdata[7:0] <= d_in[15:8];
        else rdata <= {8'h00, lat_addr[0] ? d_in[15:8] : d_in[7:0]};
      end

      if (go_ts) begin
        state  <= TS;
        part   <= nxt_part;
        cnt    <= 8'h0;
        bus_oe <= 1'b1;
        _ads   <= 1'b0;
        a      <= part_addr[23:1];
        _bhe   <= lane_bhe_n;
        _ble   <= lane_ble_n;
        wr     <= lat_wr;
        mio    <= lat_mio;
        dc     <= 1'b1;
        d_out  <= lane_dout;
        d_oe   <= 1'b0;
      end

      if (go_tc) begin
        state <= TC;
        cnt   <= 8'h0;
        _ads  <= 1'b1;
        d_oe  <= lat_wr;
      end

      if (go_rel) begin
        state  <= REL;
        hold   <= 1'b0;
        bus_oe <= 1'b0;
        d_oe   <= 1'b0;
        _ads   <= 1'b1;
        _bhe   <= 1'b1;
        _ble   <= 1'b1;
        wr     <= 1'b0;
        mio    <= 1'b0;
        dc     <= 1'b0;
        done   <= 1'b1;
        err    <= rel_err;
      end
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: a bus agent answers hold/_ads, and a
// scoreboard queue holds the expected {err, rdata} of each transaction.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req_wr, req_mio, req_word;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic        hold, hlda, bus_oe;
  logic [23:1] a;
  logic        _bhe, _ble, _ads, wr, mio, dc;
  logic [15:0] d_out, d_in;
  logic        d_oe, _ready;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  logic [15:0] model_rdata;

  int          ads_n, ads_bad, doe_bad, hold_cnt, tc_total;
  bit          got_done;
  logic        obs_err, obs_hold_rel, obs_oe_rel, obs_busy_rel;
  logic [15:0] obs_rdata;
  logic [22:0] obs_a[4];
  logic        obs_bhe[4], obs_ble[4], obs_mio[4], obs_wr[4], obs_dc[4];
  logic [15:0] obs_dout[4];

  bus_master #(.TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_mio(req_mio),
    .req_addr(req_addr), .req_word(req_word), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .hold(hold), .hlda(hlda),
    .bus_oe(bus_oe), .a(a), ._bhe(_bhe), ._ble(_ble), ._ads(_ads), .wr(wr),
    .mio(mio), .dc(dc), .d_out(d_out), .d_oe(d_oe), .d_in(d_in), ._ready(_ready),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] exp_read(input logic [23:0] ad, input logic wd,
                                           input logic [15:0] di);
    if (wd && !ad[0]) return di;
    if (wd) return {di[7:0], di[15:8]};
    if (ad[0]) return {8'h00, di[15:8]};
    return {8'h00, di[7:0]};
  endfunction

  // driver task: issues one req and plays the bus agent until done or budget
  task automatic do_txn(input logic t_wr, input logic t_mio, input logic [23:0] t_addr,
                        input logic t_word, input logic [15:0] t_wdata,
                        input int hlda_dly, input int rdy_wait, input logic [15:0] din,
                        input bit drop_tc, input bit spam_req, input int budget);
    bit in_tc, dropped, prev_ads_low;
    int tc_run;
    ads_n = 0; ads_bad = 0; doe_bad = 0; hold_cnt = 0; tc_total = 0; got_done = 0;
    obs_err = 1'b0; obs_rdata = 16'h0; obs_hold_rel = 1'b1; obs_oe_rel = 1'b1;
    obs_busy_rel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs_a[i] = '0; obs_bhe[i] = 1'b1; obs_ble[i] = 1'b1; obs_mio[i] = 1'b0;
      obs_wr[i] = 1'b0; obs_dc[i] = 1'b0; obs_dout[i] = '0;
    end
    dropped = 0; prev_ads_low = 0; tc_run = 0;
    d_in = din;
    @(negedge clk);
    req_wr = t_wr; req_mio = t_mio; req_addr = t_addr; req_word = t_word;
    req_wdata = t_wdata; req = 1'b1;
    @(negedge clk);
    req = spam_req;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        got_done = 1; obs_err = err; obs_rdata = rdata; obs_hold_rel = hold;
        obs_oe_rel = bus_oe; obs_busy_rel = busy;
        break;
      end
      if (hold) hold_cnt++;
      if (!_ads) begin
        if (prev_ads_low || !hlda || !bus_oe) ads_bad++;
        if (ads_n < 4) begin
          obs_a[ads_n] = a; obs_bhe[ads_n] = _bhe; obs_ble[ads_n] = _ble;
          obs_mio[ads_n] = mio; obs_wr[ads_n] = wr; obs_dc[ads_n] = dc;
          obs_dout[ads_n] = d_out;
        end
        ads_n++;
        tc_run = 0;
      end
      prev_ads_low = !_ads;
      in_tc = bus_oe && _ads;
      if (in_tc) begin
        tc_run++; tc_total++;
        if (d_oe !== t_wr) doe_bad++;
      end else if (d_oe !== 1'b0) begin
        doe_bad++;
      end
      if (drop_tc && in_tc) dropped = 1;
      hlda   = (hlda_dly >= 0) && (hold_cnt > hlda_dly) && !dropped;
      _ready = !(in_tc && rdy_wait >= 0 && tc_run >= rdy_wait);
      if (spam_req) begin
        req_addr = 24'($urandom); req_wdata = 16'($urandom); req_wr = ~t_wr;
      end
      @(negedge clk);
    end
    req = 1'b0; hlda = 1'b0; _ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_mio = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; hlda = 1'b0; _ready = 1'b1; d_in = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hold, bus_oe, d_oe, _ads, _bhe, _ble, wr, mio, dc, busy, done, err} !== 12'b000111000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000111000000",
               {hold, bus_oe, d_oe, _ads, _bhe, _ble, wr, mio, dc, busy, done, err});
    end
    n_checks++;
    if ({a, d_out, rdata} !== 55'h0) begin
      n_fail++; $display("FAIL reset_data: a=%h d_out=%h rdata=%h expected 0", a, d_out, rdata);
    end
    n_checks++;
    if (state_dbg !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    reset = 1'b0;
    model_rdata = 16'h0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hold !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b hold=%b expected 0 0", busy, hold);
    end
  endtask

  task automatic test_word_read();
    exp_q.push_back({1'b0, 16'hBEEF});
    do_txn(1'b0, 1'b1, 24'h012344, 1'b1, 16'h0000, 3, 2, 16'hBEEF, 0, 0, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL word_read_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    model_rdata = 16'hBEEF;
    n_checks++;
    if (ads_n !== 1 || ads_bad !== 0 || obs_a[0] !== 23'h0091A2 || {obs_bhe[0], obs_ble[0]} !== 2'b00) begin
      n_fail++; $display("FAIL word_read_bus: ads=%0d bad=%0d a=%h bhe_ble=%b expected 1 0 0091a2 00", ads_n, ads_bad, obs_a[0], {obs_bhe[0], obs_ble[0]});
    end
    n_checks++;
    if ({obs_mio[0], obs_wr[0], obs_dc[0]} !== 3'b101 || hold_cnt !== 7 || tc_total !== 2) begin
      n_fail++; $display("FAIL word_read_timing: mio_wr_dc=%b hold=%0d tc=%0d expected 101 7 2", {obs_mio[0], obs_wr[0], obs_dc[0]}, hold_cnt, tc_total);
    end
    n_checks++;
    if (obs_hold_rel !== 1'b0 || obs_oe_rel !== 1'b0 || obs_busy_rel !== 1'b1) begin
      n_fail++; $display("FAIL word_read_rel: hold=%b oe=%b busy=%b expected 0 0 1", obs_hold_rel, obs_oe_rel, obs_busy_rel);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL word_read_after: done=%b busy=%b rdata=%h expected 0 0 beef", done, busy, rdata);
    end
  endtask

  task automatic test_odd_word_write();
    exp_q.push_back({1'b0, model_rdata});
    do_txn(1'b1, 1'b1, 24'h000101, 1'b1, 16'hA55A, 0, 1, 16'h0000, 0, 0, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL odd_write_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    n_checks++;
    if (ads_n !== 2 || ads_bad !== 0 || doe_bad !== 0 || obs_wr[0] !== 1'b1) begin
      n_fail++; $display("FAIL odd_write_pulses: ads=%0d bad=%0d doe_bad=%0d wr=%b expected 2 0 0 1", ads_n, ads_bad, doe_bad, obs_wr[0]);
    end
    n_checks++;
    if (obs_a[0] !== 23'h80 || {obs_bhe[0], obs_ble[0]} !== 2'b01 || obs_dout[0][15:8] !== 8'h5A) begin
      n_fail++; $display("FAIL odd_write_part1: a=%h bhe_ble=%b d=%h expected 80 01 5a", obs_a[0], {obs_bhe[0], obs_ble[0]}, obs_dout[0][15:8]);
    end
    n_checks++;
    if (obs_a[1] !== 23'h81 || {obs_bhe[1], obs_ble[1]} !== 2'b10 || obs_dout[1][7:0] !== 8'hA5) begin
      n_fail++; $display("FAIL odd_write_part2: a=%h bhe_ble=%b d=%h expected 81 10 a5", obs_a[1], {obs_bhe[1], obs_ble[1]}, obs_dout[1][7:0]);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL odd_write_single_done: done=%b expected 0", done);
    end
  endtask

  task automatic test_byte_read_io();
    exp_q.push_back({1'b0, 16'h007F});
    do_txn(1'b0, 1'b0, 24'h000061, 1'b0, 16'h0000, 1, 1, 16'h7F00, 0, 0, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL byte_read_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    model_rdata = 16'h007F;
    n_checks++;
    if (ads_n !== 1 || obs_mio[0] !== 1'b0 || {obs_bhe[0], obs_ble[0]} !== 2'b01 || obs_a[0] !== 23'h30) begin
      n_fail++; $display("FAIL byte_read_bus: ads=%0d mio=%b bhe_ble=%b a=%h expected 1 0 01 30", ads_n, obs_mio[0], {obs_bhe[0], obs_ble[0]}, obs_a[0]);
    end
  endtask

  task automatic test_wrap_word_read();
    exp_q.push_back({1'b0, 16'h963C});
    do_txn(1'b0, 1'b1, 24'hFFFFFF, 1'b1, 16'h0000, 2, 3, 16'h3C96, 0, 0, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL wrap_read_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    model_rdata = 16'h963C;
    n_checks++;
    if (ads_n !== 2 || ads_bad !== 0 || obs_a[0] !== 23'h7FFFFF || obs_a[1] !== 23'h0 ||
        {obs_bhe[0], obs_ble[0], obs_bhe[1], obs_ble[1]} !== 4'b0110) begin
      n_fail++; $display("FAIL wrap_read_bus: ads=%0d a0=%h a1=%h lanes=%b expected 2 7fffff 0 0110", ads_n, obs_a[0], obs_a[1], {obs_bhe[0], obs_ble[0], obs_bhe[1], obs_ble[1]});
    end
  endtask

  task automatic test_req_ignored();
    exp_q.push_back({1'b0, model_rdata});
    do_txn(1'b1, 1'b1, 24'h000A40, 1'b0, 16'h0066, 1, 2, 16'h0000, 0, 1, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL busy_req_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    n_checks++;
    if (ads_n !== 1 || obs_a[0] !== 23'h000520 || {obs_bhe[0], obs_ble[0]} !== 2'b10 || obs_dout[0][7:0] !== 8'h66) begin
      n_fail++; $display("FAIL busy_req_bus: ads=%0d a=%h bhe_ble=%b d=%h expected 1 000520 10 66", ads_n, obs_a[0], {obs_bhe[0], obs_ble[0]}, obs_dout[0][7:0]);
    end
    begin
      int busy_seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (busy !== 1'b0) busy_seen++;
      end
      n_checks++;
      if (busy_seen !== 0) begin
        n_fail++; $display("FAIL busy_req_queued: busy cycles=%0d expected 0", busy_seen);
      end
    end
  endtask

  task automatic test_hreq_timeout();
    exp_q.push_back({1'b1, model_rdata});
    do_txn(1'b0, 1'b1, 24'h123456, 1'b1, 16'h0000, -1, 1, 16'h0000, 0, 0, 400);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL hreq_timeout_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    n_checks++;
    if (ads_n !== 0 || hold_cnt !== 255 || obs_hold_rel !== 1'b0 || obs_oe_rel !== 1'b0) begin
      n_fail++; $display("FAIL hreq_timeout_bus: ads=%0d hold=%0d hold_rel=%b oe=%b expected 0 255 0 0", ads_n, hold_cnt, obs_hold_rel, obs_oe_rel);
    end
  endtask

  task automatic test_tc_timeout();
    exp_q.push_back({1'b1, model_rdata});
    do_txn(1'b1, 1'b1, 24'h002000, 1'b1, 16'h1234, 0, -1, 16'h0000, 0, 0, 400);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL tc_timeout_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    n_checks++;
    if (tc_total !== 255 || ads_n !== 1 || doe_bad !== 0 || obs_hold_rel !== 1'b0) begin
      n_fail++; $display("FAIL tc_timeout_bus: tc=%0d ads=%0d doe_bad=%0d hold=%b expected 255 1 0 0", tc_total, ads_n, doe_bad, obs_hold_rel);
    end
  endtask

  task automatic test_hlda_drop();
    exp_q.push_back({1'b1, model_rdata});
    do_txn(1'b0, 1'b1, 24'h004000, 1'b1, 16'h0000, 0, -1, 16'hFFFF, 1, 0, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL hlda_drop_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    n_checks++;
    if (tc_total !== 1) begin
      n_fail++; $display("FAIL hlda_drop_latency: tc cycles=%0d expected 1", tc_total);
    end
  endtask

  task automatic test_reset_in_tc();
    int found = 0;
    int done_seen = 0;
    @(negedge clk);
    req_wr = 1'b1; req_mio = 1'b1; req_addr = 24'h000200; req_word = 1'b1;
    req_wdata = 16'h9999; req = 1'b1;
    @(negedge clk);
    req = 1'b0; hlda = 1'b1; _ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus_oe && _ads && d_oe) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (found !== 1) begin
      n_fail++; $display("FAIL reset_tc_reach: reached TC=%0d expected 1", found);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({d_oe, hold, _ads, busy, done, bus_oe} !== 6'b001000) begin
      n_fail++; $display("FAIL reset_tc_immediate: d_oe_hold_ads_busy_done_oe=%b expected 001000", {d_oe, hold, _ads, busy, done, bus_oe});
    end
    hlda = 1'b0;
    model_rdata = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++; $display("FAIL reset_tc_no_done: active cycles=%0d expected 0", done_seen);
    end
    exp_q.push_back({1'b0, model_rdata});
    do_txn(1'b1, 1'b1, 24'h000033, 1'b0, 16'h00C3, 1, 1, 16'h0000, 0, 0, 100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
      n_fail++; $display("FAIL reset_tc_next_result: done=%0b err_rdata=%h expected %h", got_done, {obs_err, obs_rdata}, exp_v);
    end
    n_checks++;
    if (ads_n !== 1 || obs_a[0] !== 23'h19 || {obs_bhe[0], obs_ble[0]} !== 2'b01 || obs_dout[0][15:8] !== 8'hC3) begin
      n_fail++; $display("FAIL reset_tc_next_bus: ads=%0d a=%h bhe_ble=%b d=%h expected 1 19 01 c3", ads_n, obs_a[0], {obs_bhe[0], obs_ble[0]}, obs_dout[0][15:8]);
    end
  endtask

  task automatic test_back_to_back();
    logic        t_wr, t_word, t_mio;
    logic [23:0] t_addr;
    logic [15:0] t_wdata, t_din, t_exp;
    int          hd, rw;
    for (int n = 0; n < 10; n++) begin
      t_wr = 1'($urandom_range(0, 1)); t_word = 1'($urandom_range(0, 1));
      t_mio = 1'($urandom_range(0, 1)); t_addr = 24'($urandom);
      t_wdata = 16'($urandom); t_din = 16'($urandom);
      hd = $urandom_range(0, 3); rw = $urandom_range(1, 3);
      t_exp = t_wr ? model_rdata : exp_read(t_addr, t_word, t_din);
      exp_q.push_back({1'b0, t_exp});
      do_txn(t_wr, t_mio, t_addr, t_word, t_wdata, hd, rw, t_din, 0, 0, 100);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (!got_done || {obs_err, obs_rdata} !== exp_v) begin
        n_fail++; $display("FAIL b2b_result[%0d]: done=%0b err_rdata=%h expected %h", n, got_done, {obs_err, obs_rdata}, exp_v);
      end
      model_rdata = t_exp;
      n_checks++;
      if (ads_n !== ((t_word && t_addr[0]) ? 2 : 1) || obs_a[0] !== t_addr[23:1] ||
          ads_bad !== 0 || doe_bad !== 0 || obs_mio[0] !== t_mio) begin
        n_fail++; $display("FAIL b2b_bus[%0d]: ads=%0d a=%h bad=%0d doe_bad=%0d mio=%b expected a=%h mio=%b", n, ads_n, obs_a[0], ads_bad, doe_bad, obs_mio[0], t_addr[23:1], t_mio);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_odd_word_write();
    test_byte_read_io();
    test_wrap_word_read();
    test_req_ignored();
    test_hreq_timeout();
    test_tc_timeout();
    test_hlda_drop();
    test_reset_in_tc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
